// File: rtl/y86_mem_bridge.sv
// Bridges the y86 core bus to a word-aligned req/ack memory, splitting unaligned
// accesses into two words. Optional one-entry last-word read cache: Y86_LAST_WORD_CACHE_EN.
module y86_mem_bridge #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_A,
    input  logic              cpu_RE,
    input  logic              cpu_WE,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              timeout
);

    localparam int WA_W  = ADDR_W - 2;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, W0, W1, DONE} state_t;

    function automatic logic [31:0] lo_word(input logic [31:0] d, input logic [1:0] o);
        return d << {o, 3'b000};
    endfunction

    function automatic logic [31:0] hi_word(input logic [31:0] d, input logic [1:0] o);
        return 32'(({32'b0, d} << {o, 3'b000}) >> 32);
    endfunction

    function automatic logic [3:0] be_lo(input logic [1:0] o);
        return 4'hF << o;
    endfunction

    function automatic logic [3:0] be_hi(input logic [1:0] o);
        return 4'((8'h0F << o) >> 4);
    endfunction

    function automatic logic [31:0] assemble(input logic [31:0] hi, input logic [31:0] lo,
                                             input logic [1:0] o);
        return 32'({hi, lo} >> {o, 3'b000});
    endfunction

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [31:0]       word0_q, word0_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_d, mwdata_d;
    logic              req_d, we_d, timeout_d;
    logic [3:0]        be_d;
    logic [WA_W-1:0]   maddr_d;

    logic [1:0]        off_in, off;
    logic [WA_W-1:0]   wa0_in, wa1_in, wa0, wa1;
    logic              hit0_in, hit1;
    logic [31:0]       cache_word;

    assign off_in = cpu_A[1:0];
    assign off    = addr_q[1:0];
    assign wa0_in = cpu_A[ADDR_W-1:2];
    assign wa1_in = wa0_in + 1'b1;
    assign wa0    = addr_q[ADDR_W-1:2];
    assign wa1    = wa0 + 1'b1;

`ifdef Y86_LAST_WORD_CACHE_EN
    logic            cache_vld, cache_vld_d;
    logic [WA_W-1:0] cache_addr, cache_addr_d;
    logic [31:0]     cache_data, cache_data_d;

    assign hit0_in    = cache_vld && (cache_addr == wa0_in);
    assign hit1       = cache_vld && !wr_q && (cache_addr == wa1);
    assign cache_word = cache_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_vld  <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
        end else begin
            cache_vld  <= cache_vld_d;
            cache_addr <= cache_addr_d;
            cache_data <= cache_data_d;
        end
    end
`else
    assign hit0_in    = 1'b0;
    assign hit1       = 1'b0;
    assign cache_word = '0;
`endif

    assign cpu_stall = ((state == IDLE) && (cpu_RE || cpu_WE)) || (state == W0) || (state == W1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            word0_q   <= '0;
            cnt_q     <= '0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            word0_q   <= word0_d;
            cnt_q     <= cnt_d;
            cpu_rdata <= rdata_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_be    <= be_d;
            mem_addr  <= maddr_d;
            mem_wdata <= mwdata_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        word0_d   = word0_q;
        cnt_d     = cnt_q;
        rdata_d   = cpu_rdata;
        req_d     = mem_req;
        we_d      = mem_we;
        be_d      = mem_be;
        maddr_d   = mem_addr;
        mwdata_d  = mem_wdata;
        timeout_d = timeout;
`ifdef Y86_LAST_WORD_CACHE_EN
        cache_vld_d  = cache_vld;
        cache_addr_d = cache_addr;
        cache_data_d = cache_data;
`endif
        case (state)
            IDLE: begin
                if (cpu_WE) begin
                    state_d  = W0;
                    addr_d   = cpu_A;
                    wdata_d  = cpu_wdata;
                    wr_d     = 1'b1;
                    req_d    = 1'b1;
                    we_d     = 1'b1;
                    maddr_d  = wa0_in;
                    be_d     = be_lo(off_in);
                    mwdata_d = lo_word(cpu_wdata, off_in);
`ifdef Y86_LAST_WORD_CACHE_EN
                    if ((cache_addr == wa0_in) || ((off_in != 2'd0) && (cache_addr == wa1_in)))
                        cache_vld_d = 1'b0;
`endif
                end else if (cpu_RE) begin
                    addr_d   = cpu_A;
                    wdata_d  = cpu_wdata;
                    wr_d     = 1'b0;
                    we_d     = 1'b0;
                    be_d     = 4'hF;
                    mwdata_d = '0;
                    if (hit0_in) begin
                        word0_d = cache_word;
                        if (off_in == 2'd0) begin
                            state_d = DONE;
                            rdata_d = cache_word;
                        end else begin
                            state_d = W1;
                            req_d   = 1'b1;
                            maddr_d = wa1_in;
                        end
                    end else begin
                        state_d = W0;
                        req_d   = 1'b1;
                        maddr_d = wa0_in;
                    end
                end
            end
            W0, W1: begin
                if (mem_ack) begin
                    if (state == W0) begin
                        word0_d = mem_rdata;
`ifdef Y86_LAST_WORD_CACHE_EN
                        if (!wr_q) begin
                            cache_vld_d  = 1'b1;
                            cache_addr_d = wa0;
                            cache_data_d = mem_rdata;
                        end
`endif
                        if (off == 2'd0) begin
                            state_d = DONE;
                            req_d   = 1'b0;
                            if (!wr_q) rdata_d = mem_rdata;
                        end else if (hit1) begin
                            state_d = DONE;
                            req_d   = 1'b0;
                            rdata_d = assemble(cache_word, mem_rdata, off);
                        end else begin
                            // req stays high straight into the second word
                            state_d = W1;
                            maddr_d = wa1;
                            if (wr_q) begin
                                be_d     = be_hi(off);
                                mwdata_d = hi_word(wdata_q, off);
                            end
                        end
                    end else begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        if (!wr_q) begin
                            rdata_d = assemble(mem_rdata, word0_q, off);
`ifdef Y86_LAST_WORD_CACHE_EN
                            cache_vld_d  = 1'b1;
                            cache_addr_d = wa1;
                            cache_data_d = mem_rdata;
`endif
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    if (!wr_q) rdata_d = '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state) cnt_d = '0;
    end

endmodule

// File: tb/tb_y86_mem_bridge.sv
// Directed bench for y86_mem_bridge: a negedge memory responder with programmable
// ack delay logs every completed word transaction for checking.
module tb_y86_mem_bridge;

    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] cpu_A;
    logic              cpu_RE, cpu_WE;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              cpu_stall, mem_req, mem_we, mem_ack, timeout;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    y86_mem_bridge #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .cpu_A(cpu_A), .cpu_RE(cpu_RE), .cpu_WE(cpu_WE),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout(timeout)
    );

    logic [31:0] mem [16];
    int          ack_en, ack_delay, waitcnt;
    logic [29:0] lg_addr[$];
    logic        lg_we[$];
    logic [3:0]  lg_be[$];
    logic [31:0] lg_wd[$];
    int          n_cmp, n_bad;

    always @(negedge clk) begin
        if (mem_req && ack_en != 0) begin
            if (waitcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[3:0]];
                lg_addr.push_back(mem_addr);
                lg_we.push_back(mem_we);
                lg_be.push_back(mem_be);
                lg_wd.push_back(mem_wdata);
                waitcnt = 0;
            end else begin
                mem_ack = 1'b0;
                waitcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            waitcnt = 0;
        end
    end

    task automatic clear_log();
        lg_addr.delete(); lg_we.delete(); lg_be.delete(); lg_wd.delete();
    endtask

    // Drives one core access and holds the strobes through the DONE edge.
    task automatic cpu_access(input logic [31:0] a, input logic re, input logic we,
                              input logic [31:0] wd, output int stalls, output logic [31:0] rd,
                              output logic req_done, output logic to_done, output bit ok);
        bit done;
        @(negedge clk);
        cpu_A = a; cpu_RE = re; cpu_WE = we; cpu_wdata = wd;
        stalls = 0; done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            if (cpu_stall) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        ok = done; rd = cpu_rdata; req_done = mem_req; to_done = timeout;
        @(posedge clk);
        #1;
        cpu_RE = 1'b0; cpu_WE = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        n_cmp++; if (mem_be !== 4'h0) begin n_bad++; $display("FAIL reset_be: got %h expected 0", mem_be); end
        n_cmp++; if (mem_addr !== 30'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_aligned_read();
        int st; logic [31:0] rd; logic rq, to; bit ok;
        clear_log(); ack_en = 1; ack_delay = 1;
        cpu_access(32'h10, 1'b1, 1'b0, 32'h0, st, rd, rq, to, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL aligned_done: access never completed"); end
        n_cmp++; if (rd !== 32'h44332211) begin n_bad++; $display("FAIL aligned_rdata: got %h expected 44332211", rd); end
        n_cmp++; if (st != 3) begin n_bad++; $display("FAIL aligned_stall: got %0d expected 3", st); end
        n_cmp++; if (rq !== 1'b0) begin n_bad++; $display("FAIL aligned_req_done: got %b expected 0", rq); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (lg_addr.size() != 1) begin n_bad++; $display("FAIL aligned_nreq: got %0d expected 1", lg_addr.size()); end
        else begin
            n_cmp++; if (lg_addr[0] !== 30'h4) begin n_bad++; $display("FAIL aligned_addr: got %h expected 4", lg_addr[0]); end
            n_cmp++; if (lg_be[0] !== 4'hF || lg_we[0] !== 1'b0) begin n_bad++; $display("FAIL aligned_be_we: got %h/%b expected f/0", lg_be[0], lg_we[0]); end
        end
    endtask

    task automatic test_unaligned_read();
        int st; logic [31:0] rd; logic rq, to; bit ok;
        clear_log(); ack_en = 1; ack_delay = 0;
        cpu_access(32'h13, 1'b1, 1'b0, 32'h0, st, rd, rq, to, ok);
        n_cmp++; if (rd !== 32'h77665544) begin n_bad++; $display("FAIL unaligned_rdata: got %h expected 77665544", rd); end
`ifdef Y86_LAST_WORD_CACHE_EN
        n_cmp++; if (st != 2) begin n_bad++; $display("FAIL unaligned_stall: got %0d expected 2", st); end
        n_cmp++; if (lg_addr.size() != 1) begin n_bad++; $display("FAIL unaligned_nreq: got %0d expected 1", lg_addr.size()); end
        else begin
            n_cmp++; if (lg_addr[0] !== 30'h5) begin n_bad++; $display("FAIL unaligned_addr1: got %h expected 5", lg_addr[0]); end
        end
`else
        n_cmp++; if (st != 3) begin n_bad++; $display("FAIL unaligned_stall: got %0d expected 3", st); end
        n_cmp++; if (lg_addr.size() != 2) begin n_bad++; $display("FAIL unaligned_nreq: got %0d expected 2", lg_addr.size()); end
        else begin
            n_cmp++; if (lg_addr[0] !== 30'h4) begin n_bad++; $display("FAIL unaligned_addr0: got %h expected 4", lg_addr[0]); end
            n_cmp++; if (lg_addr[1] !== 30'h5) begin n_bad++; $display("FAIL unaligned_addr1: got %h expected 5", lg_addr[1]); end
        end
`endif
    endtask

    task automatic test_unaligned_write();
        int st; logic [31:0] rd; logic rq, to; bit ok;
        clear_log(); ack_en = 1; ack_delay = 0;
        cpu_access(32'h22, 1'b0, 1'b1, 32'hAABBCCDD, st, rd, rq, to, ok);
        n_cmp++; if (st != 3) begin n_bad++; $display("FAIL uwrite_stall: got %0d expected 3", st); end
        n_cmp++; if (rd !== 32'h77665544) begin n_bad++; $display("FAIL uwrite_rdata_hold: got %h expected 77665544", rd); end
        n_cmp++; if (lg_addr.size() != 2) begin n_bad++; $display("FAIL uwrite_nreq: got %0d expected 2", lg_addr.size()); end
        else begin
            n_cmp++; if (lg_addr[0] !== 30'h8 || lg_we[0] !== 1'b1) begin n_bad++; $display("FAIL uwrite_w0_addr: got %h/%b expected 8/1", lg_addr[0], lg_we[0]); end
            n_cmp++; if (lg_be[0] !== 4'b1100) begin n_bad++; $display("FAIL uwrite_w0_be: got %b expected 1100", lg_be[0]); end
            n_cmp++; if (lg_wd[0] !== 32'hCCDD0000) begin n_bad++; $display("FAIL uwrite_w0_data: got %h expected ccdd0000", lg_wd[0]); end
            n_cmp++; if (lg_addr[1] !== 30'h9 || lg_we[1] !== 1'b1) begin n_bad++; $display("FAIL uwrite_w1_addr: got %h/%b expected 9/1", lg_addr[1], lg_we[1]); end
            n_cmp++; if (lg_be[1] !== 4'b0011) begin n_bad++; $display("FAIL uwrite_w1_be: got %b expected 0011", lg_be[1]); end
            n_cmp++; if (lg_wd[1] !== 32'h0000AABB) begin n_bad++; $display("FAIL uwrite_w1_data: got %h expected 0000aabb", lg_wd[1]); end
        end
    endtask

    task automatic test_write_priority();
        int st; logic [31:0] rd; logic rq, to; bit ok;
        clear_log(); ack_en = 1; ack_delay = 0;
        cpu_access(32'h30, 1'b1, 1'b1, 32'h12345678, st, rd, rq, to, ok);
        n_cmp++; if (st != 2) begin n_bad++; $display("FAIL prio_stall: got %0d expected 2", st); end
        n_cmp++; if (lg_addr.size() != 1) begin n_bad++; $display("FAIL prio_nreq: got %0d expected 1", lg_addr.size()); end
        else begin
            n_cmp++; if (lg_we[0] !== 1'b1 || lg_addr[0] !== 30'hC) begin n_bad++; $display("FAIL prio_we_addr: got %b/%h expected 1/c", lg_we[0], lg_addr[0]); end
            n_cmp++; if (lg_be[0] !== 4'hF || lg_wd[0] !== 32'h12345678) begin n_bad++; $display("FAIL prio_be_data: got %h/%h expected f/12345678", lg_be[0], lg_wd[0]); end
        end
    endtask

    task automatic test_wrap();
        int st; logic [31:0] rd; logic rq, to; bit ok;
        clear_log(); ack_en = 1; ack_delay = 0;
        cpu_access(32'hFFFFFFFD, 1'b1, 1'b0, 32'h0, st, rd, rq, to, ok);
        n_cmp++; if (rd !== 32'h44DDCCBB) begin n_bad++; $display("FAIL wrap_rdata: got %h expected 44ddccbb", rd); end
        n_cmp++; if (lg_addr.size() != 2) begin n_bad++; $display("FAIL wrap_nreq: got %0d expected 2", lg_addr.size()); end
        else begin
            n_cmp++; if (lg_addr[0] !== 30'h3FFFFFFF) begin n_bad++; $display("FAIL wrap_addr0: got %h expected 3fffffff", lg_addr[0]); end
            n_cmp++; if (lg_addr[1] !== 30'h0) begin n_bad++; $display("FAIL wrap_addr1: got %h expected 0", lg_addr[1]); end
        end
    endtask

    task automatic test_timeout();
        int st; logic [31:0] rd; logic rq, to; bit ok;
        clear_log(); ack_en = 0; ack_delay = 0;
        cpu_access(32'h40, 1'b1, 1'b0, 32'h0, st, rd, rq, to, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout_done: stall never released"); end
        n_cmp++; if (st != 5) begin n_bad++; $display("FAIL timeout_stall: got %0d expected 5", st); end
        n_cmp++; if (to !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b expected 1", to); end
        n_cmp++; if (rq !== 1'b0) begin n_bad++; $display("FAIL timeout_req: got %b expected 0", rq); end
        n_cmp++; if (rd !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL timeout_rdata: got %h expected ffffffff", rd); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b expected 1", timeout); end
    endtask

    task automatic test_reset_mid_w1();
        bit seen; int n;
        clear_log(); ack_en = 1; ack_delay = 2; seen = 0;
        @(negedge clk);
        cpu_A = 32'h13; cpu_RE = 1'b1; cpu_WE = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_addr == 30'h5) seen = 1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL midrst_reach_w1: second word request never seen"); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 30'h0) begin n_bad++; $display("FAIL midrst_req_addr: got %b/%h expected 0/0", mem_req, mem_addr); end
        n_cmp++; if (mem_be !== 4'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL midrst_be_we_wd: got %h/%b/%h expected 0/0/0", mem_be, mem_we, mem_wdata); end
        n_cmp++; if (cpu_rdata !== 32'h0 || timeout !== 1'b0) begin n_bad++; $display("FAIL midrst_rdata_to: got %h/%b expected 0/0", cpu_rdata, timeout); end
        n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL midrst_idle_stall: got %b expected 1", cpu_stall); end
        cpu_RE = 1'b0;
        #1;
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %b expected 0", cpu_stall); end
        @(negedge clk);
        rst = 1'b1;
        n = lg_addr.size();
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (lg_addr.size() != n || mem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_no_retry: got %0d reqs req=%b expected %0d req=0", lg_addr.size(), mem_req, n); end
    endtask

    task automatic test_last_word_cache();
        int st; logic [31:0] rd; logic rq, to; bit ok;
        clear_log(); ack_en = 1; ack_delay = 0;
        cpu_access(32'h10, 1'b1, 1'b0, 32'h0, st, rd, rq, to, ok);
        n_cmp++; if (rd !== 32'h44332211 || lg_addr.size() != 1) begin n_bad++; $display("FAIL cache_first: got %h/%0d reqs expected 44332211/1", rd, lg_addr.size()); end
        clear_log();
        cpu_access(32'h10, 1'b1, 1'b0, 32'h0, st, rd, rq, to, ok);
        n_cmp++; if (rd !== 32'h44332211) begin n_bad++; $display("FAIL cache_repeat_rdata: got %h expected 44332211", rd); end
`ifdef Y86_LAST_WORD_CACHE_EN
        n_cmp++; if (lg_addr.size() != 0 || st != 1) begin n_bad++; $display("FAIL cache_repeat: got %0d reqs stall %0d expected 0/1", lg_addr.size(), st); end
`else
        n_cmp++; if (lg_addr.size() != 1 || st != 2) begin n_bad++; $display("FAIL cache_repeat: got %0d reqs stall %0d expected 1/2", lg_addr.size(), st); end
`endif
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; cpu_A = '0; cpu_RE = 1'b0; cpu_WE = 1'b0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; ack_en = 0; ack_delay = 0; waitcnt = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4]  = 32'h44332211;
        mem[5]  = 32'h88776655;
        mem[15] = 32'hDDCCBBAA;
        mem[0]  = 32'h11223344;
        test_reset();
        test_aligned_read();
        test_unaligned_read();
        test_unaligned_write();
        test_write_priority();
        test_wrap();
        test_timeout();
        test_reset_mid_w1();
        test_last_word_cache();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
